// File: rtl/serial_pattern_detector_if.sv
// Bundles the serial sample/clear inputs and the detector outputs for serial_pattern_detector.
interface serial_pattern_detector_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             d;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             filled;

  modport master (
    output en, clr, d,
    input  match, match_count, filled
  );

  modport slave (
    input  en, clr, d,
    output match, match_count, filled
  );
endinterface

// File: rtl/serial_pattern_detector.sv
// Serial PAT_W-bit pattern detector with a registered match pulse and a saturating match count.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; the default is non-overlapping.
module serial_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input logic                    clk,
  input logic                    reset,
  serial_pattern_detector_if.slave bus
);

  localparam int               FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CMAX  = {CNT_W{1'b1}};

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic              filled_q, filled_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic             d_s;
  logic [PAT_W-1:0] window_s;
  logic             hit_s;

  // Next-state logic: history shift, fill tracking, hit detection and count update.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    // Gate d with en so an undriven bit cannot reach the compare while idle.
    d_s      = bus.en ? bus.d : 1'b0;
    window_s = {hist_q, d_s};
    hit_s    = bus.en && (fill_q == FULL) && (window_s == PATTERN);

    if (bus.en) begin
      hist_d = window_s[PAT_W-2:0];
      if (hit_s) begin
`ifdef SEQ_DET_OVERLAP_EN
        fill_d = FULL;
`else
        fill_d = '0;
`endif
      end else if (fill_q != FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end

    if (bus.clr) begin
      cnt_d = '0;
    end else if (hit_s && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    match_d  = hit_s;
    filled_d = (fill_d == FULL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
      filled_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      filled_q <= filled_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.filled      = filled_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed plus randomized bench for serial_pattern_detector against a queue-based reference model.
module tb_serial_pattern_detector;

  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int               CNT_W   = 2;
  localparam int               CMAX    = (1 << CNT_W) - 1;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Reference state: bits accepted since the last reset (or last hit when not overlapping).
  bit   mq[$];
  bit   exp_match;
  int   exp_cnt;
  bit   exp_filled;

  serial_pattern_detector_if #(.CNT_W(CNT_W)) bus ();

  serial_pattern_detector #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit r, input bit e, input bit c, input logic dd, input string tag);
    bit hit;
    int w;
    reset  = r;
    bus.en = e;
    bus.clr = c;
    bus.d  = dd;
    hit = 1'b0;
    if (!r) begin
      mq.delete();
      exp_match  = 1'b0;
      exp_cnt    = 0;
      exp_filled = 1'b0;
    end else begin
      if (e) begin
        if (mq.size() == PAT_W - 1) begin
          w = 0;
          foreach (mq[i]) w = w * 2 + int'(mq[i]);
          w = w * 2 + int'(dd);
          hit = (w == int'(PATTERN));
        end
        if (hit && !OVERLAP) begin
          mq.delete();
        end else begin
          mq.push_back(bit'(dd));
          if (mq.size() > PAT_W - 1) void'(mq.pop_front());
        end
      end
      exp_match = hit;
      if (c) exp_cnt = 0;
      else if (hit && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
      exp_filled = (mq.size() == PAT_W - 1);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (bus.match === exp_match) else begin
      errors++;
      $error("FAIL %s match obs=%0b exp=%0b", tag, bus.match, exp_match);
    end
    checks++;
    assert (bus.match_count === CNT_W'(exp_cnt)) else begin
      errors++;
      $error("FAIL %s match_count obs=%0d exp=%0d", tag, bus.match_count, exp_cnt);
    end
    checks++;
    assert (bus.filled === exp_filled) else begin
      errors++;
      $error("FAIL %s filled obs=%0b exp=%0b", tag, bus.filled, exp_filled);
    end
  endtask

  task automatic feed(input logic [6:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, 1'b0, bits[i], tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.d = 1'b0;

    step(1'b0, 1'b1, 1'b1, 1'b1, "reset0");
    step(1'b0, 1'b0, 1'b0, 1'b0, "reset1");

    // Stream 1,0,1,1,0,1,1: one or two hits depending on overlap mode.
    feed(7'b1011011, 7, "stream");
    step(1'b1, 1'b1, 1'b0, 1'b0, "stream_tail");

    // Reset mid-pattern must discard the partial history.
    step(1'b0, 1'b1, 1'b1, 1'b0, "clr_pre");
    feed(7'b0000101, 3, "pre_rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, "mid_rst");
    step(1'b1, 1'b1, 1'b0, 1'b1, "post_rst");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post_rst_idle");

    // Enable gaps with X on d while idle.
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_rst");
    feed(7'b0000010, 2, "gap_a");
    step(1'b1, 1'b0, 1'b0, 1'b0,  "gap_idle0");
    step(1'b1, 1'b0, 1'b0, 1'bx,  "gap_idle1");
    step(1'b1, 1'b0, 1'b0, 1'b0,  "gap_idle2");
    feed(7'b0000011, 2, "gap_b");
    step(1'b1, 1'b0, 1'b0, 1'bx,  "gap_after");

    // Saturation: five separated 1011 patterns.
    step(1'b0, 1'b0, 1'b0, 1'b0, "sat_rst");
    for (int k = 0; k < 5; k++) feed(7'b0001011, 4, "sat");
    step(1'b1, 1'b0, 1'b0, 1'b0, "sat_hold");

    // clr colliding with a hit when count is 2.
    step(1'b0, 1'b0, 1'b0, 1'b0, "clr_rst");
    feed(7'b0001011, 4, "clr_p1");
    feed(7'b0001011, 4, "clr_p2");
    feed(7'b0000101, 3, "clr_p3");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
    step(1'b1, 1'b0, 1'b0, 1'b0, "clr_after");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit   r, e, c;
      logic dd;
      r  = ($urandom_range(59) != 0);
      e  = ($urandom_range(4) != 0);
      c  = ($urandom_range(24) == 0);
      dd = e ? logic'($urandom_range(1)) : (($urandom_range(1) != 0) ? 1'bx : 1'b0);
      step(r, e, c, dd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
